// File: rtl/glyph_plot_ctrl.sv
// Draws one 8x16 glyph: loads the pixel shift register, then plots each pixel in raster order.
// Latency: 130 cycles start-to-done at full rate; backpressure: plot_ready=0 holds the current pixel (skipped pixels never stall).
module glyph_plot_ctrl #(
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 16,
    parameter int COLS    = 20,
    parameter int ROWS    = 7,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int C_W     = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [GLYPH_W*GLYPH_H-1:0]   glyph,
    input  logic [4:0]                   cell_col,
    input  logic [2:0]                   cell_row,
    input  logic [C_W-1:0]               fg,
    input  logic [C_W-1:0]               bg,
    input  logic                         transparent,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [GLYPH_W*GLYPH_H-1:0]   sr_load_val,
    output logic                         sr_load,
    output logic                         sr_shift,
    input  logic                         sr_bit,
    output logic                         plot_valid,
    input  logic                         plot_ready,
    output logic [X_W-1:0]               plot_x,
    output logic [Y_W-1:0]               plot_y,
    output logic [C_W-1:0]               plot_colour
);

    localparam int NPIX = GLYPH_W * GLYPH_H;
    localparam int NB   = $clog2(NPIX);
    localparam int XB   = $clog2(GLYPH_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NB-1:0]   pix_n;
    logic [NB-1:0]   pix_nxt;
    logic [X_W-1:0]  base_x;
    logic [Y_W-1:0]  base_y;
    logic [C_W-1:0]  fg_r;
    logic [C_W-1:0]  bg_r;
    logic            transp_r;
    logic            cell_ok;
    logic            skip;

    assign cell_ok = (32'(cell_col) < COLS) && (32'(cell_row) < ROWS);
    assign skip    = transp_r & ~sr_bit;
    assign pix_nxt = pix_n + NB'(1);

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign sr_load     = (state == LOAD);
    // sr_bit is only meaningful once the register has been loaded, so colour is gated to DRAW
    assign plot_colour = (state == DRAW) ? (sr_bit ? fg_r : bg_r) : '0;

    always_comb begin
        state_nxt  = state;
        plot_valid = 1'b0;
        sr_shift   = 1'b0;
        case (state)
            IDLE: begin
                if (start && cell_ok) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = DRAW;
            end
            DRAW: begin
                plot_valid = ~skip;
                sr_shift   = skip | plot_ready;
                if (sr_shift && (pix_n == NB'(NPIX - 1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            pix_n       <= '0;
            base_x      <= '0;
            base_y      <= '0;
            fg_r        <= '0;
            bg_r        <= '0;
            transp_r    <= 1'b0;
            sr_load_val <= '0;
            plot_x      <= '0;
            plot_y      <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cell_ok) begin
                            sr_load_val <= glyph;
                            base_x      <= X_W'(cell_col * GLYPH_W);
                            base_y      <= Y_W'(cell_row * GLYPH_H);
                            fg_r        <= fg;
                            bg_r        <= bg;
                            transp_r    <= transparent;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    pix_n  <= '0;
                    plot_x <= base_x;
                    plot_y <= base_y;
                end
                DRAW: begin
                    // coordinates move only when the current pixel is consumed, so they hold during a stall
                    if (sr_shift) begin
                        pix_n  <= pix_nxt;
                        plot_x <= base_x + X_W'(pix_nxt[XB-1:0]);
                        plot_y <= base_y + Y_W'(pix_nxt[NB-1:XB]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_plot_ctrl.sv
// Randomized bench for glyph_plot_ctrl: shift-register model drives sr_bit, a scoreboard checks every accepted plot.
module tb_glyph_plot_ctrl;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [127:0] glyph = '0;
    logic [4:0]   cell_col = '0;
    logic [2:0]   cell_row = '0;
    logic [2:0]   fg = '0;
    logic [2:0]   bg = '0;
    logic         transparent = 1'b0;
    logic         busy, done, err, sr_load, sr_shift, sr_bit, plot_valid;
    logic         plot_ready;
    logic [127:0] sr_load_val;
    logic [7:0]   plot_x;
    logic [6:0]   plot_y;
    logic [2:0]   plot_colour;

    glyph_plot_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .glyph(glyph),
        .cell_col(cell_col), .cell_row(cell_row), .fg(fg), .bg(bg),
        .transparent(transparent), .busy(busy), .done(done), .err(err),
        .sr_load_val(sr_load_val), .sr_load(sr_load), .sr_shift(sr_shift),
        .sr_bit(sr_bit), .plot_valid(plot_valid), .plot_ready(plot_ready),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour)
    );

    always #5 clock = ~clock;

    // external pixel shift register; deliberately unaffected by the controller reset
    logic [127:0] sr_q = '0;
    always @(posedge clock) begin
        if (sr_load) sr_q <= sr_load_val;
        else if (sr_shift) sr_q <= {sr_q[126:0], 1'b0};
    end
    assign sr_bit = sr_q[127];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int rdy_mode = 0;
    int t_ref = 0;
    initial begin
        plot_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0:       plot_ready = 1'b1;
                1:       plot_ready = ((cyc - t_ref) % 2 == 0);
                default: plot_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } plot_t;

    plot_t        exp_q[$];
    plot_t        exp_p;
    plot_t        held;
    int           n_cmp = 0;
    int           n_bad = 0;
    bit           mon_en = 1'b1;
    bit           stall_prev = 1'b0;
    int           shift_cnt, load_cnt, done_cnt, err_cnt, acc_cnt, valid_cnt, done_cyc;
    logic [127:0] exp_glyph;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en && reset) begin
            if (sr_shift) shift_cnt++;
            if (plot_valid) valid_cnt++;
            if (err) err_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (sr_load) begin
                load_cnt++;
                chk("sr_load_val", sr_load_val, exp_glyph);
                chk("shift_with_load", sr_shift, 0);
            end
            if (stall_prev) begin
                chk("stall_valid", plot_valid, 1);
                chk("stall_hold", {plot_x, plot_y, plot_colour}, held);
            end
            if (plot_valid && plot_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected none", plot_x, plot_y, plot_colour);
                end else begin
                    exp_p = exp_q.pop_front();
                    chk("plot_xyc", {plot_x, plot_y, plot_colour}, exp_p);
                end
            end
            stall_prev = plot_valid && !plot_ready;
            held = {plot_x, plot_y, plot_colour};
        end else begin
            stall_prev = 1'b0;
        end
    end

    // reference: walk the bitmap in raster order, plotting every set pixel and (if opaque) every clear one
    task automatic push_expected(input logic [127:0] g, input int col, input int row,
                                 input logic [2:0] f, input logic [2:0] b, input logic tr);
        plot_t p;
        for (int n = 0; n < 128; n++) begin
            if (tr && !g[127-n]) continue;
            p.x = 8'(col * 8 + n % 8);
            p.y = 7'(row * 16 + n / 8);
            p.c = g[127-n] ? f : b;
            exp_q.push_back(p);
        end
    endtask

    task automatic run_cmd(input logic [127:0] g, input int col, input int row,
                           input logic [2:0] f, input logic [2:0] b, input logic tr,
                           input int rmode, input int exp_lat, input int poke_at, input int abort_at);
        bit ok;
        int t0;
        int waited;
        ok = (col < 20) && (row < 7);
        @(negedge clock);
        waited = 0;
        while (busy && waited < 3000) begin
            @(negedge clock);
            waited++;
        end
        shift_cnt = 0; load_cnt = 0; done_cnt = 0; err_cnt = 0; acc_cnt = 0; valid_cnt = 0;
        exp_glyph = g;
        rdy_mode = rmode;
        glyph = g; cell_col = 5'(col); cell_row = 3'(row); fg = f; bg = b; transparent = tr;
        start = 1'b1;
        t0 = cyc;
        t_ref = t0;
        if (ok) push_expected(g, col, row, f, b, tr);
        @(negedge clock);
        start = 1'b0;
        chk("busy_T1", busy, ok);
        chk("err_T1", err, !ok);
        chk("sr_load_T1", sr_load, ok);
        if (ok) begin
            waited = 0;
            while (done_cnt == 0 && waited < 3000) begin
                @(negedge clock);
                waited++;
                start = (waited == poke_at);
                if (waited == poke_at) begin
                    glyph = ~g;
                    cell_col = 5'd20;
                end
                if (abort_at >= 0 && acc_cnt >= abort_at) begin
                    reset = 1'b0;
                    mon_en = 1'b0;
                    @(negedge clock);
                    chk("abort_outputs", {busy, done, err, sr_load, sr_shift, plot_valid, plot_x, plot_y, plot_colour}, 0);
                    chk("abort_load_val", sr_load_val, 0);
                    chk("abort_done_pulses", done_cnt, 0);
                    exp_q.delete();
                    reset = 1'b1;
                    mon_en = 1'b1;
                    return;
                end
            end
            start = 1'b0;
            if (done_cnt == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_timeout: got no done expected done within 3000 cycles");
            end else if (exp_lat > 0) begin
                chk("done_latency", done_cyc - t0, exp_lat);
            end
            @(negedge clock);
            @(negedge clock);
            chk("idle_after", busy, 0);
            chk("plots_left", exp_q.size(), 0);
            chk("shift_count", shift_cnt, 128);
            chk("load_count", load_cnt, 1);
            chk("done_pulses", done_cnt, 1);
            chk("no_err", err_cnt, 0);
        end else begin
            repeat (3) @(negedge clock);
            chk("rej_loads", load_cnt, 0);
            chk("rej_plots", valid_cnt, 0);
            chk("rej_busy", busy, 0);
            chk("rej_err_pulses", err_cnt, 1);
        end
    endtask

    initial begin
        logic [127:0] corners;
        logic [127:0] rg;
        int           rm;
        corners = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {busy, done, err, sr_load, sr_shift, plot_valid, plot_x, plot_y, plot_colour}, 0);
        chk("reset_load_val", sr_load_val, 0);
        reset = 1'b1;

        run_cmd({128{1'b1}}, 0, 0, 3'd7, 3'd0, 1'b0, 0, 130, -1, -1);
        run_cmd(corners, 19, 6, 3'd2, 3'd5, 1'b0, 0, 130, -1, -1);
        run_cmd(corners, 19, 6, 3'd2, 3'd5, 1'b1, 0, 130, -1, -1);
        chk("transp_valid_cycles", valid_cnt, 2);
        run_cmd({$urandom, $urandom, $urandom, $urandom}, 3, 2, 3'd4, 3'd1, 1'b0, 1, 257, -1, -1);

        run_cmd(corners, 20, 0, 3'd1, 3'd2, 1'b0, 0, -1, -1, -1);
        run_cmd(corners, 0, 7, 3'd1, 3'd2, 1'b0, 0, -1, -1, -1);
        run_cmd(corners, 31, 7, 3'd1, 3'd2, 1'b0, 0, -1, -1, -1);

        run_cmd({$urandom, $urandom, $urandom, $urandom}, 5, 1, 3'd6, 3'd3, 1'b0, 0, -1, -1, 40);
        run_cmd({$urandom, $urandom, $urandom, $urandom}, 7, 4, 3'd3, 3'd6, 1'b0, 0, 130, -1, -1);
        run_cmd({$urandom, $urandom, $urandom, $urandom}, 2, 5, 3'd5, 3'd2, 1'b0, 0, 130, 20, -1);

        for (int i = 0; i < 12; i++) begin
            rg = {$urandom, $urandom, $urandom, $urandom};
            rm = $urandom_range(0, 2);
            run_cmd(rg, $urandom_range(0, 21), $urandom_range(0, 7), 3'($urandom), 3'($urandom),
                    1'($urandom), rm, (rm == 0) ? 130 : -1, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/glyph_plot_ctrl.md
# glyph_plot_ctrl

Sequencer that draws one 8x16 character glyph through the 128-bit pixel shift register and out to the frame-buffer plot port. It accepts a draw command (glyph bitmap, text-cell column/row, colours), loads the shift register, and then issues one plot per pixel in raster order, shifting the register as each plot is accepted. It sits between the text-editor command logic and the pixel shift register / VGA adapter pair.

## Interface
- GLYPH_W, 8, glyph width in pixels; GLYPH_W*GLYPH_H = 128
- GLYPH_H, 16, glyph height in pixels
- COLS, 20, text-cell columns (160 px / 8)
- ROWS, 7, text-cell rows (120 px / 16)
- X_W, 8, plot_x width
- Y_W, 7, plot_y width
- C_W, 3, colour width

- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- start  in  1  draw request; sampled only in IDLE
- glyph  in  128  bitmap; bit 127 = top-left pixel, raster order, MSB first
- cell_col  in  5  target column
- cell_row  in  3  target row
- fg, bg  in  C_W  foreground / background colour
- transparent  in  1  1 = skip background pixels (no plot)
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: out-of-range cell rejected
- sr_load_val  out  128  latched glyph to shift register
- sr_load  out  1  one-cycle load strobe to shift register
- sr_shift  out  1  advance shift register by one
- sr_bit  in  1  shift register MSB (current pixel)
- plot_valid  out  1  plot request
- plot_ready  in  1  frame buffer accepts plot
- plot_x  out  X_W  pixel x
- plot_y  out  Y_W  pixel y
- plot_colour  out  C_W  pixel colour

## Operation
- States: IDLE, LOAD, DRAW, DONE.
- IDLE: start=1 with cell_col<COLS and cell_row<ROWS latches glyph, base_x=cell_col*8, base_y=cell_row*16, fg, bg, transparent -> LOAD. Out-of-range cell: err=1 next cycle, stay IDLE. start outside IDLE ignored (no err).
- LOAD: sr_load=1, sr_load_val=latched glyph, pixel index n=0 -> DRAW.
- DRAW: current pixel n (0..127); plot_x=base_x+n[2:0], plot_y=base_y+n[6:3]; plot_colour = sr_bit ? fg : bg.
  - Normal: plot_valid=1; on plot_valid&plot_ready: sr_shift=1, n++.
  - transparent=1 and sr_bit=0: plot_valid=0, sr_shift=1, n++ unconditionally (plot_ready ignored).
  - Advance out of n=127 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- sr_shift, plot_valid combinational from state, sr_bit, plot_ready; all else registered. sr_shift never coincident with sr_load.
- plot_x/y/colour held stable while plot_valid=1 and plot_ready=0.
- Reset (any state): IDLE next cycle; busy, done, err, sr_load, sr_shift, plot_valid = 0; plot_x, plot_y, plot_colour, sr_load_val, n = 0. Partially drawn glyph is abandoned; shift register is not reloaded.

## Timing
- Start accepted cycle T; LOAD at T+1 (busy=1 from T+1); first DRAW at T+2.
- plot_ready held 1, transparent=0: pixels at T+2..T+129, done=1 at T+130, busy=0 and next start accepted at T+131.
- Each cycle plot_ready=0 (non-skipped pixel) adds one cycle; skipped pixels take exactly one cycle.
- busy=1 in LOAD, DRAW, DONE; 0 in IDLE.
- err pulse at T+1 for rejected start; busy stays 0.

## Test plan
- glyph=all-ones, cell (0,0), fg=7, plot_ready=1 -> 128 plots, colour 7, x 0..7 per row, y 0..15, done at T+130.
- glyph=128'h8000...0001, cell (19,6), fg=2, bg=5 -> first plot (152,96) colour 2, last plot (159,111) colour 2, all others colour 5.
- Same glyph, transparent=1 -> exactly 2 plot_valid cycles, 128 sr_shift pulses total, done at T+130.
- plot_ready toggled 1/0 each cycle -> outputs stable while stalled, 128 accepted plots, done at T+257.
- cell_col=20 or cell_row=7 -> err pulse at T+1, busy=0, no sr_load, no plot.
- reset low at pixel 40 -> next cycle IDLE, all outputs 0; subsequent start draws full glyph from pixel 0; start during busy ignored.
